// File: rtl/sysid_ext_pkg.sv
// ---------------------------------------------------------------------------
// sysid_ext_pkg
// Shared constants for the extended system-ID slave: data width, register
// word offsets and CTRL bit positions.
// ---------------------------------------------------------------------------
package sysid_ext_pkg;

    localparam int DATA_W = 32;

    // Word offsets within the 8-word register window
    localparam logic [2:0] OFF_ID       = 3'd0;
    localparam logic [2:0] OFF_TS       = 3'd1;
    localparam logic [2:0] OFF_HWVER    = 3'd2;
    localparam logic [2:0] OFF_UPTIME   = 3'd3;
    localparam logic [2:0] OFF_CYCLE_LO = 3'd4;
    localparam logic [2:0] OFF_CYCLE_HI = 3'd5;
    localparam logic [2:0] OFF_SCRATCH  = 3'd6;
    localparam logic [2:0] OFF_CTRL     = 3'd7;

    // CTRL register bit indices
    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;

endpackage

// File: rtl/sysid_uptime_counter.sv
// ---------------------------------------------------------------------------
// sysid_uptime_counter
// Live time base: a prescaler dividing the clock down to seconds, a 32-bit
// seconds counter and a free-running 64-bit cycle counter.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   clear_i   zero all counters at this edge (wins over counting and freeze)
//   freeze_i  hold all counters
//   uptime_o  seconds since reset/clear
//   cycle_o   clock cycles since reset/clear
// ---------------------------------------------------------------------------
module sysid_uptime_counter
    import sysid_ext_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ_HZ = 32'd50000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        freeze_i,
    output logic [31:0] uptime_o,
    output logic [63:0] cycle_o
);

    localparam logic [31:0] PRESC_TERM = CLK_FREQ_HZ - 32'd1;

    logic [31:0] presc_q,  presc_d;
    logic [31:0] uptime_q, uptime_d;
    logic [63:0] cycle_q,  cycle_d;

    always_comb begin
        presc_d  = presc_q;
        uptime_d = uptime_q;
        cycle_d  = cycle_q;
        if (clear_i) begin
            presc_d  = '0;
            uptime_d = '0;
            cycle_d  = '0;
        end else if (!freeze_i) begin
            cycle_d = cycle_q + 64'd1;
            if (presc_q == PRESC_TERM) begin
                presc_d  = '0;
                uptime_d = uptime_q + 32'd1;  // wraps naturally at 2^32
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            uptime_q <= '0;
            cycle_q  <= '0;
        end else begin
            presc_q  <= presc_d;
            uptime_q <= uptime_d;
            cycle_q  <= cycle_d;
        end
    end

    assign uptime_o = uptime_q;
    assign cycle_o  = cycle_q;

endmodule

// File: rtl/niosii_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// niosii_system_sysid_ext
// Avalon-MM slave (read latency 1, no waitrequest) exposing system ID, build
// timestamp, hardware version, uptime seconds, a 64-bit cycle count with a
// coherent high-word shadow, a scratch register and a control register.
//
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   address        word address (ADDR_W bits; offsets >= 8 read 0)
//   read / write   access strobes; read wins when both are high
//   writedata      write data
//   byteenable     byte lanes for writes
//   readdata       registered read data, holds between reads
//   readdatavalid  high the cycle after an accepted read
// ---------------------------------------------------------------------------
module niosii_system_sysid_ext
    import sysid_ext_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'd1487796770,
    parameter logic [31:0] HW_VERSION  = 32'h0001_0000,
    parameter logic [31:0] CLK_FREQ_HZ = 32'd50000000,
    parameter int          ADDR_W      = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [3:0]        byteenable,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    logic [31:0] uptime;
    logic [63:0] cycle;

    logic [31:0] scratch_q, scratch_d;
    logic        freeze_q,  freeze_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        rvalid_q,  rvalid_d;

    logic        in_map;
    logic [2:0]  off;
    logic        wr_en;
    logic        ctrl_wr;
    logic        clear;
    logic [31:0] rd_mux;

    // Only the low 3 address bits select a register; anything above the
    // 8-word window is unmapped.
    assign in_map  = (address >> 3) == '0;
    assign off     = address[2:0];
    assign wr_en   = write && !read && in_map;
    assign ctrl_wr = wr_en && (off == OFF_CTRL) && byteenable[0];
    assign clear   = ctrl_wr && writedata[CTRL_CLEAR];

    sysid_uptime_counter #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_cnt (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .clear_i  (clear),
        .freeze_i (freeze_q),
        .uptime_o (uptime),
        .cycle_o  (cycle)
    );

    always_comb begin
        rd_mux = '0;
        if (in_map) begin
            case (off)
                OFF_ID:       rd_mux = ID_VALUE;
                OFF_TS:       rd_mux = TIMESTAMP;
                OFF_HWVER:    rd_mux = HW_VERSION;
                OFF_UPTIME:   rd_mux = uptime;
                OFF_CYCLE_LO: rd_mux = cycle[31:0];
                OFF_CYCLE_HI: rd_mux = shadow_q;
                OFF_SCRATCH:  rd_mux = scratch_q;
                OFF_CTRL:     rd_mux = {30'd0, freeze_q, 1'b0};  // CLEAR reads 0
                default:      rd_mux = '0;
            endcase
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        rvalid_d  = read;

        if (wr_en && off == OFF_SCRATCH) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) scratch_d[b*8 +: 8] = writedata[b*8 +: 8];
            end
        end
        if (ctrl_wr) freeze_d = writedata[CTRL_FREEZE];

        if (read) begin
            rdata_d = rd_mux;
            // Reading the low word snapshots the high word so software sees a
            // coherent 64-bit value even if the counter carries in between.
            if (in_map && off == OFF_CYCLE_LO) shadow_d = cycle[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= '0;
            freeze_q  <= 1'b0;
            shadow_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            freeze_q  <= freeze_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// tb_niosii_system_sysid_ext
// Directed-vector bench for the extended system-ID slave (CLK_FREQ_HZ=10 so
// the uptime second is 10 cycles). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_niosii_system_sysid_ext;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    niosii_system_sysid_ext #(
        .CLK_FREQ_HZ (32'd10),
        .ADDR_W      (3)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clock);
        write = 1'b0; byteenable = '0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        chk({tag, "_vld"}, {31'd0, readdatavalid}, 32'd1);
        chk(tag, readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clock);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_rvalid", {31'd0, readdatavalid}, 32'd0);
        reset_n = 1'b1;

        // Read sampled on edge 36 after release sees 35 increments -> 3 s
        idle(35);
        rd("uptime_35", 3'd3, 32'd3);

        rd("id", 3'd0, 32'h0000_0000);
        rd("timestamp", 3'd1, 32'd1487796770);
        rd("hwver", 3'd2, 32'h0001_0000);
        chk("rvalid_drop", {31'd0, readdatavalid}, 32'd1);
        @(negedge clock);
        chk("rvalid_idle", {31'd0, readdatavalid}, 32'd0);
        chk("rdata_hold", readdata, 32'h0001_0000);
        rd("ctrl_rst", 3'd7, 32'd0);

        // Uptime wrap: exactly one tick falls in any 10 consecutive edges
        force dut.u_cnt.uptime_q = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.u_cnt.uptime_q;
        idle(10);
        rd("uptime_wrap", 3'd3, 32'd0);

        // Scratch byte lanes, read-only write, read+write collision
        wr(3'd6, 32'hDEAD_BEEF, 4'b1111);
        wr(3'd6, 32'h0000_0011, 4'b0001);
        rd("scratch_be", 3'd6, 32'hDEAD_BE11);
        wr(3'd0, 32'h1234_5678, 4'b1111);
        rd("id_ro", 3'd0, 32'h0000_0000);
        address = 3'd6; writedata = 32'h0; byteenable = 4'hF; read = 1'b1; write = 1'b1;
        @(negedge clock);
        read = 1'b0; write = 1'b0; byteenable = '0;
        chk("rw_read", readdata, 32'hDEAD_BE11);
        rd("rw_nowrite", 3'd6, 32'hDEAD_BE11);
        wr(3'd6, 32'h1234_5678, 4'b1010);
        rd("scratch_1010", 3'd6, 32'h12AD_5611);

        // Coherent high word: counter held at the preload during the LO read
        force dut.u_cnt.cycle_q = 64'h0000_0001_FFFF_FFFE;
        @(negedge clock);
        rd("cycle_lo", 3'd4, 32'hFFFF_FFFE);
        release dut.u_cnt.cycle_q;
        idle(2);
        rd("cycle_hi_shadow", 3'd5, 32'h0000_0001);

        // Clear (not frozen), then freeze on the next edge: one count slips in
        wr(3'd7, 32'h1, 4'b0001);
        rd("shadow_kept", 3'd5, 32'h0000_0001);
        wr(3'd7, 32'h2, 4'b0001);
        // the shadow read above also took one count before the freeze edge
        idle(20);
        rd("frozen_cycle", 3'd4, 32'd2);
        rd("frozen_uptime", 3'd3, 32'd0);
        rd("ctrl_frozen", 3'd7, 32'h2);

        wr(3'd7, 32'h3, 4'b0001);
        idle(5);
        rd("clr_frozen_cycle", 3'd4, 32'd0);
        rd("ctrl_still_frozen", 3'd7, 32'h2);

        wr(3'd7, 32'h0, 4'b0001);
        idle(5);
        rd("resume_cycle", 3'd4, 32'd5);
        rd("ctrl_resume", 3'd7, 32'h0);

        // Reset in the cycle after a read drops the completion
        address = 3'd6; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'd0, readdatavalid}, 32'd0);
        chk("rst_mid_rdata", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_no_cpl", {31'd0, readdatavalid}, 32'd0);
        rd("scratch_after_rst", 3'd6, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
